dyn_reconf: RTL and testbench

Dynamic reconfiguration port (DRP) block for the behavioural MMCM/PLL model. It holds the MMCM clock-control registers (XAPP888 layout), writable and readable over a DRP-style bus. From the stored values and the current VCO period it continuously decodes divide, duty-cycle and phase settings for CLKOUT0–6, CLKFBOUT and DIVCLK. Those settings feed the clock-generation core.

---
 rtl/dyn_reconf_pkg.sv | 63 ++++++
 rtl/dyn_reconf_clkreg_decode.sv | 41 ++++
 rtl/dyn_reconf.sv | 135 +++++++++++++
 tb/tb_dyn_reconf.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dyn_reconf_pkg.sv
// Shared constants for the MMCM DRP register block: addresses, field positions,
// reset words and the counter-to-register mapping.
package dyn_reconf_pkg;

    localparam logic [6:0] ADDR_CLKOUT5_R1 = 7'h06;
    localparam logic [6:0] ADDR_CLKOUT0_R1 = 7'h08;
    localparam logic [6:0] ADDR_CLKOUT1_R1 = 7'h0A;
    localparam logic [6:0] ADDR_CLKOUT2_R1 = 7'h0C;
    localparam logic [6:0] ADDR_CLKOUT3_R1 = 7'h0E;
    localparam logic [6:0] ADDR_CLKOUT4_R1 = 7'h10;
    localparam logic [6:0] ADDR_CLKOUT6_R1 = 7'h12;
    localparam logic [6:0] ADDR_CLKFB_R1   = 7'h14;
    localparam logic [6:0] ADDR_DIVCLK     = 7'h16;
    localparam logic [6:0] ADDR_FIRST      = ADDR_CLKOUT5_R1;
    localparam logic [6:0] ADDR_LAST       = ADDR_DIVCLK;
    localparam int         NUM_REGS        = 17;
    localparam int         NUM_COUNTERS    = 8;   // CLKOUT0..6 plus CLKFBOUT
    localparam int         FB_IDX          = 7;
    localparam int         DIVCLK_IDX      = int'(ADDR_DIVCLK - ADDR_FIRST);

    // Reg1 fields
    localparam int R1_PM_LSB   = 13;
    localparam int R1_HIGH_LSB = 6;
    localparam int R1_LOW_LSB  = 0;
    // Reg2 fields
    localparam int R2_FRAC_LSB = 12;
    localparam int R2_FRAC_EN  = 11;
    localparam int R2_EDGE     = 7;
    localparam int R2_NO_COUNT = 6;
    localparam int R2_DLY_LSB  = 0;
    // DIVCLK fields
    localparam int DV_EDGE     = 13;
    localparam int DV_NO_COUNT = 12;

    localparam logic [15:0] RST_REG1   = 16'h0041;
    localparam logic [15:0] RST_REG2   = 16'h0040;
    localparam logic [15:0] RST_DIVCLK = 16'h1000;

    // Storage index 0 maps to ADDR_FIRST, which is a Reg1 address, so even
    // indices are Reg1 words and odd indices Reg2 words.
    function automatic logic [15:0] reset_word(input int idx);
        if (idx == DIVCLK_IDX)
            return RST_DIVCLK;
        else if ((idx % 2) == 0)
            return RST_REG1;
        else
            return RST_REG2;
    endfunction

    function automatic int counter_reg1_idx(input int n);
        case (n)
            0:       return int'(ADDR_CLKOUT0_R1 - ADDR_FIRST);
            1:       return int'(ADDR_CLKOUT1_R1 - ADDR_FIRST);
            2:       return int'(ADDR_CLKOUT2_R1 - ADDR_FIRST);
            3:       return int'(ADDR_CLKOUT3_R1 - ADDR_FIRST);
            4:       return int'(ADDR_CLKOUT4_R1 - ADDR_FIRST);
            5:       return int'(ADDR_CLKOUT5_R1 - ADDR_FIRST);
            6:       return int'(ADDR_CLKOUT6_R1 - ADDR_FIRST);
            default: return int'(ADDR_CLKFB_R1 - ADDR_FIRST);
        endcase
    endfunction

endpackage

// File: rtl/dyn_reconf_clkreg_decode.sv
// Decodes one counter's Reg1/Reg2 pair into divide, duty cycle x1000 and
// phase delay in ns for the given VCO period.
module clkreg_decode
    import dyn_reconf_pkg::*;
(
    input  logic [15:0] reg1_i,
    input  logic [15:0] reg2_i,
    input  logic [31:0] vco_period_1000_i,
    output logic [31:0] divide_o,
    output logic [31:0] duty_1000_o,
    output logic [31:0] phase_o
);

    logic [5:0]  high_f, low_f, delay_f;
    logic [2:0]  pm_f;
    logic        edge_f, no_count_f;
    logic [31:0] high_cnt, low_cnt, period_cnt, duty_num, phase_steps, phase_prod;
    logic        unused_bits;

    assign high_f     = reg1_i[R1_HIGH_LSB +: 6];
    assign low_f      = reg1_i[R1_LOW_LSB +: 6];
    assign pm_f       = reg1_i[R1_PM_LSB +: 3];
    assign delay_f    = reg2_i[R2_DLY_LSB +: 6];
    assign edge_f     = reg2_i[R2_EDGE];
    assign no_count_f = reg2_i[R2_NO_COUNT];
    // FRAC and the mux bits only matter to the feedback path, handled by the top.
    assign unused_bits = ^{reg1_i[12], reg2_i[15:8]};

    always_comb begin
        high_cnt    = (high_f == 6'd0) ? 32'd64 : {26'd0, high_f};
        low_cnt     = (low_f == 6'd0) ? 32'd64 : {26'd0, low_f};
        period_cnt  = high_cnt + low_cnt;
        duty_num    = ({high_cnt[30:0], 1'b0} + {31'd0, edge_f}) * 32'd500;
        phase_steps = {29'd0, pm_f} + {23'd0, delay_f, 3'b000};
        phase_prod  = vco_period_1000_i * phase_steps;
        divide_o    = no_count_f ? 32'd1 : period_cnt;
        duty_1000_o = no_count_f ? 32'd500 : duty_num / period_cnt;
        phase_o     = phase_prod / 32'd8000;
    end

endmodule

// File: rtl/dyn_reconf.sv
// MMCM DRP register file with continuous decode of the per-counter divide,
// duty-cycle and phase settings feeding the clock-generation core.
module dyn_reconf
    import dyn_reconf_pkg::*;
(
    input  logic        DCLK,
    input  logic        RST,
    input  logic        PWRDWN,
    input  logic [31:0] vco_period_1000,
    input  logic [6:0]  DADDR,
    input  logic        DEN,
    input  logic        DWE,
    input  logic [15:0] DI,
    output logic [15:0] DO,
    output logic        DRDY,
    output logic [31:0] CLKOUT0_DIVIDE,
    output logic [31:0] CLKOUT1_DIVIDE,
    output logic [31:0] CLKOUT2_DIVIDE,
    output logic [31:0] CLKOUT3_DIVIDE,
    output logic [31:0] CLKOUT4_DIVIDE,
    output logic [31:0] CLKOUT5_DIVIDE,
    output logic [31:0] CLKOUT6_DIVIDE,
    output logic [31:0] CLKOUT0_DUTY_CYCLE_1000,
    output logic [31:0] CLKOUT1_DUTY_CYCLE_1000,
    output logic [31:0] CLKOUT2_DUTY_CYCLE_1000,
    output logic [31:0] CLKOUT3_DUTY_CYCLE_1000,
    output logic [31:0] CLKOUT4_DUTY_CYCLE_1000,
    output logic [31:0] CLKOUT5_DUTY_CYCLE_1000,
    output logic [31:0] CLKOUT6_DUTY_CYCLE_1000,
    output logic [31:0] CLKOUT0_PHASE,
    output logic [31:0] CLKOUT1_PHASE,
    output logic [31:0] CLKOUT2_PHASE,
    output logic [31:0] CLKOUT3_PHASE,
    output logic [31:0] CLKOUT4_PHASE,
    output logic [31:0] CLKOUT5_PHASE,
    output logic [31:0] CLKOUT6_PHASE,
    output logic [31:0] CLKFBOUT_MULT_F_1000,
    output logic [31:0] CLKFBOUT_PHASE,
    output logic [31:0] DIVCLK_DIVIDE
);

    logic [15:0] regs_q [NUM_REGS];
    logic [15:0] do_q, do_d;
    logic        drdy_q;
    logic        addr_hit, wr_en;
    logic [6:0]  addr_off;
    logic [4:0]  addr_idx;
    logic [31:0] div_w   [NUM_COUNTERS];
    logic [31:0] duty_w  [NUM_COUNTERS];
    logic [31:0] phase_w [NUM_COUNTERS];
    logic [15:0] divclk_w, fb_reg2_w;
    logic [31:0] dv_high, dv_low, frac_term;
    logic        unused_ok;

    assign addr_hit = (DADDR >= ADDR_FIRST) && (DADDR <= ADDR_LAST);
    assign addr_off = DADDR - ADDR_FIRST;
    assign addr_idx = addr_off[4:0];
    assign wr_en    = DEN && DWE && addr_hit;

    always_comb begin
        do_d = do_q;
        if (DEN && !DWE)
            do_d = addr_hit ? regs_q[addr_idx] : 16'h0000;
    end

    always_ff @(posedge DCLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= reset_word(i);
            do_q   <= 16'h0000;
            drdy_q <= 1'b1;
        end else begin
            if (wr_en)
                regs_q[addr_idx] <= DI;
            do_q   <= do_d;
            drdy_q <= ~DEN;
        end
    end

    assign DO   = do_q;
    assign DRDY = drdy_q;

    generate
        for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_dec
            localparam int R1 = counter_reg1_idx(gi);
            clkreg_decode u_dec (
                .reg1_i            (regs_q[R1]),
                .reg2_i            (regs_q[R1 + 1]),
                .vco_period_1000_i (vco_period_1000),
                .divide_o          (div_w[gi]),
                .duty_1000_o       (duty_w[gi]),
                .phase_o           (phase_w[gi])
            );
        end
    endgenerate

    // Feedback adds the fractional eighths on top of the integer multiplier.
    assign fb_reg2_w = regs_q[counter_reg1_idx(FB_IDX) + 1];
    assign frac_term = fb_reg2_w[R2_FRAC_EN] ? {29'd0, fb_reg2_w[R2_FRAC_LSB +: 3]} * 32'd125 : 32'd0;

    assign divclk_w = regs_q[DIVCLK_IDX];
    assign dv_high  = (divclk_w[R1_HIGH_LSB +: 6] == 6'd0) ? 32'd64 : {26'd0, divclk_w[R1_HIGH_LSB +: 6]};
    assign dv_low   = (divclk_w[R1_LOW_LSB +: 6] == 6'd0) ? 32'd64 : {26'd0, divclk_w[R1_LOW_LSB +: 6]};

    assign unused_ok = ^{PWRDWN, divclk_w[15:14], divclk_w[DV_EDGE], addr_off[6:5], duty_w[FB_IDX]};

    assign CLKOUT0_DIVIDE = div_w[0];
    assign CLKOUT1_DIVIDE = div_w[1];
    assign CLKOUT2_DIVIDE = div_w[2];
    assign CLKOUT3_DIVIDE = div_w[3];
    assign CLKOUT4_DIVIDE = div_w[4];
    assign CLKOUT5_DIVIDE = div_w[5];
    assign CLKOUT6_DIVIDE = div_w[6];

    assign CLKOUT0_DUTY_CYCLE_1000 = duty_w[0];
    assign CLKOUT1_DUTY_CYCLE_1000 = duty_w[1];
    assign CLKOUT2_DUTY_CYCLE_1000 = duty_w[2];
    assign CLKOUT3_DUTY_CYCLE_1000 = duty_w[3];
    assign CLKOUT4_DUTY_CYCLE_1000 = duty_w[4];
    assign CLKOUT5_DUTY_CYCLE_1000 = duty_w[5];
    assign CLKOUT6_DUTY_CYCLE_1000 = duty_w[6];

    assign CLKOUT0_PHASE = phase_w[0];
    assign CLKOUT1_PHASE = phase_w[1];
    assign CLKOUT2_PHASE = phase_w[2];
    assign CLKOUT3_PHASE = phase_w[3];
    assign CLKOUT4_PHASE = phase_w[4];
    assign CLKOUT5_PHASE = phase_w[5];
    assign CLKOUT6_PHASE = phase_w[6];

    assign CLKFBOUT_MULT_F_1000 = div_w[FB_IDX] * 32'd1000 + frac_term;
    assign CLKFBOUT_PHASE       = phase_w[FB_IDX];
    assign DIVCLK_DIVIDE        = divclk_w[DV_NO_COUNT] ? 32'd1 : dv_high + dv_low;

endmodule

// File: tb/tb_dyn_reconf.sv
// Randomized DRP traffic checked against an address-indexed register model
// that derives every decoded output from the field rules directly.
module tb_dyn_reconf;

    logic        DCLK = 1'b0;
    logic        RST = 1'b0;
    logic        PWRDWN = 1'b0;
    logic [31:0] vco_period_1000 = 32'd32000;
    logic [6:0]  DADDR = 7'd0;
    logic        DEN = 1'b0;
    logic        DWE = 1'b0;
    logic [15:0] DI = 16'h0;
    logic [15:0] DO;
    logic        DRDY;
    logic [31:0] div_w [7];
    logic [31:0] duty_w [7];
    logic [31:0] phase_w [7];
    logic [31:0] fb_mult, fb_phase, divclk_div;

    always #5 DCLK = ~DCLK;

    dyn_reconf dut (
        .DCLK(DCLK), .RST(RST), .PWRDWN(PWRDWN), .vco_period_1000(vco_period_1000),
        .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY),
        .CLKOUT0_DIVIDE(div_w[0]), .CLKOUT1_DIVIDE(div_w[1]), .CLKOUT2_DIVIDE(div_w[2]),
        .CLKOUT3_DIVIDE(div_w[3]), .CLKOUT4_DIVIDE(div_w[4]), .CLKOUT5_DIVIDE(div_w[5]),
        .CLKOUT6_DIVIDE(div_w[6]),
        .CLKOUT0_DUTY_CYCLE_1000(duty_w[0]), .CLKOUT1_DUTY_CYCLE_1000(duty_w[1]),
        .CLKOUT2_DUTY_CYCLE_1000(duty_w[2]), .CLKOUT3_DUTY_CYCLE_1000(duty_w[3]),
        .CLKOUT4_DUTY_CYCLE_1000(duty_w[4]), .CLKOUT5_DUTY_CYCLE_1000(duty_w[5]),
        .CLKOUT6_DUTY_CYCLE_1000(duty_w[6]),
        .CLKOUT0_PHASE(phase_w[0]), .CLKOUT1_PHASE(phase_w[1]), .CLKOUT2_PHASE(phase_w[2]),
        .CLKOUT3_PHASE(phase_w[3]), .CLKOUT4_PHASE(phase_w[4]), .CLKOUT5_PHASE(phase_w[5]),
        .CLKOUT6_PHASE(phase_w[6]),
        .CLKFBOUT_MULT_F_1000(fb_mult), .CLKFBOUT_PHASE(fb_phase), .DIVCLK_DIVIDE(divclk_div)
    );

    // Reference model: register contents by address, plus DO/DRDY
    logic [15:0] m_mem [128];
    logic [15:0] m_do;
    logic        m_drdy;
    int          r1_addr [7] = '{8, 10, 12, 14, 16, 6, 18};
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic bit mapped(input int a);
        return (a >= 6) && (a <= 22);
    endfunction

    function automatic int unsigned fld_cnt(input int unsigned v);
        return (v == 0) ? 64 : v;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 128; a++) m_mem[a] = 16'h0;
        for (int a = 6; a <= 20; a += 2) begin
            m_mem[a]     = 16'h0041;  // HIGH=1, LOW=1
            m_mem[a + 1] = 16'h0040;  // NO_COUNT
        end
        m_mem[22] = 16'h1000;
        m_do      = 16'h0;
        m_drdy    = 1'b1;
    endtask

    task automatic model_dec(input logic [15:0] r1, input logic [15:0] r2,
                             output int unsigned dv, output int unsigned dt, output int unsigned ph);
        int unsigned h, l;
        longint unsigned prod;
        h  = fld_cnt(r1[11:6]);
        l  = fld_cnt(r1[5:0]);
        dv = r2[6] ? 1 : h + l;
        dt = r2[6] ? 500 : ((2 * h + r2[7]) * 500) / (h + l);
        prod = (longint'(vco_period_1000) * longint'(r1[15:13] + 8 * r2[5:0])) % 64'h1_0000_0000;
        ph = int'(prod / 8000);
    endtask

    task automatic check_all(input string ctx);
        int unsigned dv, dt, ph;
        chk({ctx, " DO"}, {16'h0, DO}, {16'h0, m_do});
        chk({ctx, " DRDY"}, {31'd0, DRDY}, {31'd0, m_drdy});
        for (int n = 0; n < 7; n++) begin
            model_dec(m_mem[r1_addr[n]], m_mem[r1_addr[n] + 1], dv, dt, ph);
            chk($sformatf("%s CLKOUT%0d_DIVIDE", ctx, n), div_w[n], dv);
            chk($sformatf("%s CLKOUT%0d_DUTY", ctx, n), duty_w[n], dt);
            chk($sformatf("%s CLKOUT%0d_PHASE", ctx, n), phase_w[n], ph);
        end
        model_dec(m_mem[20], m_mem[21], dv, dt, ph);
        chk({ctx, " FB_MULT"}, fb_mult, dv * 1000 + (m_mem[21][11] ? m_mem[21][14:12] * 125 : 0));
        chk({ctx, " FB_PHASE"}, fb_phase, ph);
        chk({ctx, " DIVCLK"}, divclk_div,
            m_mem[22][12] ? 1 : fld_cnt(m_mem[22][11:6]) + fld_cnt(m_mem[22][5:0]));
    endtask

    // One clock edge: update the model from the sampled inputs, then compare.
    task automatic step(input string ctx);
        @(posedge DCLK);
        if (RST) begin
            if (DEN && DWE && mapped(DADDR)) m_mem[DADDR] = DI;
            if (DEN && !DWE) m_do = mapped(DADDR) ? m_mem[DADDR] : 16'h0;
            m_drdy = ~DEN;
        end else begin
            model_reset();
        end
        #1 check_all(ctx);
    endtask

    task automatic drp(input logic [6:0] addr, input logic we, input logic [15:0] data, input int ncyc);
        @(negedge DCLK);
        DADDR = addr; DWE = we; DI = data; DEN = 1'b1;
        for (int c = 0; c < ncyc; c++) step(we ? "wr" : "rd");
        @(negedge DCLK);
        DEN = 1'b0;
        DWE = $urandom_range(0, 1);
        DADDR = 7'($urandom);
        step("idle");
        $display("[TB] %s addr=0x%02h data=0x%04h cyc=%0d DO=0x%04h", we ? "WR" : "RD", addr, data, ncyc, DO);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge DCLK);
        #1 check_all("reset");
        @(negedge DCLK);
        RST = 1'b1;
        step("post_reset");

        // Directed: CLKOUT0/1/5, feedback, DIVCLK
        drp(7'h09, 1'b1, 16'h0000, 1);
        drp(7'h08, 1'b1, 16'b011_0_000110_000011, 1);
        chk("c0_div_9", div_w[0], 32'd9);
        chk("c0_duty_666", duty_w[0], 32'd666);
        chk("c0_phase_12", phase_w[0], 32'd12);
        drp(7'h08, 1'b0, 16'h0, 1);
        chk("c0_readback", {16'h0, DO}, 32'h6183);
        drp(7'h09, 1'b1, 16'h0043, 1);
        chk("c0_phase_108", phase_w[0], 32'd108);
        drp(7'h0A, 1'b1, 16'h6183, 1);
        drp(7'h0B, 1'b1, 16'h0043, 1);
        drp(7'h06, 1'b1, 16'h6183, 1);
        drp(7'h07, 1'b1, 16'h0043, 1);
        drp(7'h14, 1'b1, 16'h6183, 1);
        chk("fb_phase_12", fb_phase, 32'd12);
        drp(7'h15, 1'b1, 16'h0043, 1);
        chk("fb_mult_1000", fb_mult, 32'd1000);
        drp(7'h15, 1'b1, 16'h5800, 1);    // FRAC=5, FRAC_EN
        chk("fb_mult_frac", fb_mult, 32'd9625);
        drp(7'h16, 1'b1, 16'h00C3, 1);
        chk("divclk_6", divclk_div, 32'd6);
        drp(7'h08, 1'b1, 16'h0000, 1);    // HIGH=LOW=0 -> 64 each
        drp(7'h30, 1'b0, 16'h0, 1);       // unmapped read
        drp(7'h05, 1'b1, 16'hFFFF, 1);    // unmapped write

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            logic [6:0] a;
            a = 7'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) a = 7'($urandom);
            drp(a, 1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) begin
                @(negedge DCLK);
                vco_period_1000 = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(500, 100000);
                #1 check_all("vco");
            end
            if (t == 150) begin
                @(negedge DCLK);
                DADDR = 7'h08; DWE = 1'b1; DI = 16'h1234; DEN = 1'b1;
                #2 RST = 1'b0;
                model_reset();
                #1 check_all("async_reset");
                DEN = 1'b0;
                step("in_reset");
                @(negedge DCLK);
                RST = 1'b1;
                step("reset_release");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
